// File: rtl/baud_pkg.sv
// ============================================================================
// Module  : baud_pkg
// Brief   : Shared defaults and helpers for the baud tick generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package baud_pkg;

    localparam int BAUD_DEFAULT_DIV = 313;
    localparam int BAUD_OVERSAMPLE  = 16;
    localparam int MIN_DIV          = 2;

    function automatic int clamp_div(input int d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/baud_frac_divider.sv
// ============================================================================
// Module  : baud_frac_divider
// Brief   : Fractional period counter producing the registered oversample tick.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_frac_divider
    import baud_pkg::*;
#(
    parameter int CNT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4,
    parameter int RST_CNT    = BAUD_DEFAULT_DIV - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  restart_i,
    input  logic [CNT_WIDTH-1:0]  div_i,
    input  logic [FRAC_WIDTH-1:0] frac_i,
    output logic                  reload_o,
    output logic                  os_tick_o
);

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [FRAC_WIDTH-1:0] acc_q, acc_d;
    logic                  os_tick_q, os_tick_d;
    logic [FRAC_WIDTH:0]   sum;

    always_comb begin
        reload_o  = enable_i && !restart_i && (cnt_q == '0);
        sum       = {1'b0, acc_q} + {1'b0, frac_i};
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        os_tick_d = 1'b0;
        if (!enable_i || restart_i) begin
            cnt_d = div_i - CNT_WIDTH'(1);
            acc_d = '0;
        end else if (reload_o) begin
            // Fraction overflow stretches the next period by one clock.
            cnt_d     = div_i - CNT_WIDTH'(1) + CNT_WIDTH'(sum[FRAC_WIDTH]);
            acc_d     = sum[FRAC_WIDTH-1:0];
            os_tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= CNT_WIDTH'(RST_CNT);
            acc_q     <= '0;
            os_tick_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            os_tick_q <= os_tick_d;
        end
    end

    assign os_tick_o = os_tick_q;

endmodule

`default_nettype wire

// File: rtl/baud_tick_generator.sv
// ============================================================================
// Module  : baud_tick_generator
// Brief   : Fractional-N oversample / mid-bit / bit-rate strobe generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_generator
    import baud_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int FRAC_WIDTH  = 4,
    parameter int OVERSAMPLE  = BAUD_OVERSAMPLE,
    parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [CNT_WIDTH-1:0]  divisor_int,
    input  logic [FRAC_WIDTH-1:0] divisor_frac,
    input  logic                  sync_restart,
    output logic                  os_tick,
    output logic                  mid_tick,
    output logic                  baud_clk,
    output logic                  cfg_err
);

    localparam int             PW       = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PW-1:0]  PH_LAST  = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0]  PH_MID   = PW'(OVERSAMPLE / 2 - 1);
    localparam int             RST_CNT  = clamp_div(DEFAULT_DIV) - 1;
    localparam logic           RST_ERR  = (DEFAULT_DIV < MIN_DIV);

    logic [CNT_WIDTH-1:0]  div_int_q, div_int_d, div_eff;
    logic [FRAC_WIDTH-1:0] div_frac_q, div_frac_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic                  mid_q, mid_d;
    logic                  baud_q, baud_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  reload;

    // A load is forwarded so a coincident restart or reload already uses it.
    always_comb begin
        div_int_d  = load ? divisor_int  : div_int_q;
        div_frac_d = load ? divisor_frac : div_frac_q;
        div_eff    = (div_int_d < CNT_WIDTH'(MIN_DIV)) ? CNT_WIDTH'(MIN_DIV) : div_int_d;
        cfg_err_d  = (div_int_d < CNT_WIDTH'(MIN_DIV));
    end

    baud_frac_divider #(
        .CNT_WIDTH  (CNT_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .RST_CNT    (RST_CNT)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (enable),
        .restart_i (sync_restart),
        .div_i     (div_eff),
        .frac_i    (div_frac_d),
        .reload_o  (reload),
        .os_tick_o (os_tick)
    );

    always_comb begin
        phase_d = phase_q;
        mid_d   = 1'b0;
        baud_d  = 1'b0;
        if (!enable || sync_restart) begin
            phase_d = '0;
        end else if (reload) begin
            baud_d  = (phase_q == PH_LAST);
            mid_d   = (phase_q == PH_MID);
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_int_q  <= CNT_WIDTH'(DEFAULT_DIV);
            div_frac_q <= '0;
            phase_q    <= '0;
            mid_q      <= 1'b0;
            baud_q     <= 1'b0;
            cfg_err_q  <= RST_ERR;
        end else begin
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            phase_q    <= phase_d;
            mid_q      <= mid_d;
            baud_q     <= baud_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign mid_tick = mid_q;
    assign baud_clk = baud_q;
    assign cfg_err  = cfg_err_q;

`ifdef FORMAL
    a_os_gap:   assert property (@(posedge clk) disable iff (reset) os_tick  |=> !os_tick);
    a_mid_gap:  assert property (@(posedge clk) disable iff (reset) mid_tick |=> !mid_tick);
    a_baud_gap: assert property (@(posedge clk) disable iff (reset) baud_clk |=> !baud_clk);
    a_baud_os:  assert property (@(posedge clk) disable iff (reset) baud_clk |-> os_tick);
`endif

endmodule

`default_nettype wire

// File: doc/baud_tick_generator.md
BAUD_TICK_GENERATOR -- requirements
Module: baud_tick_generator

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of integer divisor and period counter.
REQ-002 Parameter FRAC_WIDTH, default 4, width of fractional divisor and phase accumulator.
REQ-003 Parameter OVERSAMPLE, default 16, even integer >= 2, oversample ticks per bit.
REQ-004 Parameter DEFAULT_DIV, default 313, integer divisor loaded at reset (48 MHz / (9600*16) ~ 312.5).
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  run when high; hold reload state when low.
REQ-008 load  input  1  single-cycle strobe latching divisor_int/divisor_frac.
REQ-009 divisor_int  input  CNT_WIDTH  integer clocks per oversample tick.
REQ-010 divisor_frac  input  FRAC_WIDTH  fractional clocks per tick, units of 2^-FRAC_WIDTH.
REQ-011 sync_restart  input  1  single-cycle strobe realigning phase (RX start-bit edge).
REQ-012 os_tick  output  1  one-cycle oversample strobe.
REQ-013 mid_tick  output  1  one-cycle strobe at bit midpoint.
REQ-014 baud_clk  output  1  one-cycle strobe once per bit period.
REQ-015 cfg_err  output  1  high while latched divisor_int < 2.

Function
REQ-016 Active divisor D/F registers SHALL update only on reset (DEFAULT_DIV, 0) or on load; effective D = max(latched divisor_int, 2).
REQ-017 enable low: cnt <= D-1, acc <= 0, phase <= 0, all strobe outputs 0 next cycle.
REQ-018 enable high, cnt != 0: cnt <= cnt-1, os_tick <= 0.
REQ-019 enable high, cnt == 0 (reload): {carry,acc} <= acc + F; cnt <= D-1+carry; os_tick <= 1.
REQ-020 Tick period SHALL average D + F/2^FRAC_WIDTH clocks; each individual period is D or D+1; first period after enable/restart is exactly D.
REQ-021 First os_tick SHALL be high in the D-th cycle after the edge that samples enable high.
REQ-022 phase counts os_ticks modulo OVERSAMPLE; wraps OVERSAMPLE-1 -> 0.
REQ-023 baud_clk SHALL be high in the same cycle as the os_tick issued while phase == OVERSAMPLE-1, otherwise 0.
REQ-024 mid_tick SHALL be high in the same cycle as the os_tick issued while phase == OVERSAMPLE/2-1, otherwise 0.
REQ-025 Strobes SHALL never be high in two consecutive cycles (D >= 2 guarantees).
REQ-026 load while enabled: new D/F SHALL take effect at the next reload, without truncating the current period.
REQ-027 load while disabled: cnt SHALL reflect new D-1 on the following cycle.
REQ-028 sync_restart (enable high): cnt <= D-1, acc <= 0, phase <= 0, no strobe that cycle; it overrides a coincident reload.
REQ-029 load with sync_restart in the same cycle: restart SHALL use the newly loaded D/F.
REQ-030 sync_restart while enable low: no effect beyond REQ-017.
REQ-031 cfg_err registered, = (latched divisor_int < 2); clamping per REQ-016 applies meanwhile.
REQ-032 All outputs registered; no combinational input-to-output path.

Reset
REQ-033 reset SHALL asynchronously set D=DEFAULT_DIV, F=0, cnt=DEFAULT_DIV-1, acc=0, phase=0, os_tick=mid_tick=baud_clk=0, cfg_err=(DEFAULT_DIV<2).
REQ-034 reset mid-period SHALL discard partial period; after release behaviour is as REQ-021.

Structure
REQ-035 Package baud_pkg SHALL hold DEFAULT_DIV, OVERSAMPLE defaults and MIN_DIV=2.
REQ-036 Sub-module baud_frac_divider SHALL contain cnt, acc, reload logic and os_tick; top holds divisor registers, phase, baud_clk, mid_tick, cfg_err.
REQ-037 Formal build SHALL assert REQ-025 and that baud_clk implies os_tick.

Verification
REQ-038 DEFAULT_DIV=4, OVERSAMPLE=4, F=0, enable after reset -> os_tick every 4 clocks, first in 4th cycle; baud_clk every 16 clocks.
REQ-039 D=4, F=8 (FRAC_WIDTH 4) -> periods 4,5,4,5...; 16 ticks span exactly 72 clocks.
REQ-040 Mid-period load D=6 while D=4 -> current period finishes at 4, next period is 6.
REQ-041 sync_restart at phase 2, cnt 1 -> no tick that cycle; next os_tick D cycles later with phase 0; mid_tick after OVERSAMPLE/2 ticks.
REQ-042 load divisor_int=1 -> cfg_err=1, tick period 2; load 5 -> cfg_err=0, period 5.
REQ-043 reset asserted mid-period -> outputs 0 immediately (asynchronously); after release, timing identical to REQ-038.
